// File: rtl/if_pc_gen.sv
// rtl/if_pc_gen.sv - instruction-fetch PC generator with next-PC priority and optional branch predictor
// Optional feature: define IF_BHT_EN to build the 2-bit BHT plus untagged BTB predictor.
module if_pc_gen #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BHT_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   output logic        im_oe,
   output logic [31:0] im_addr,
   output logic [31:0] pc_out,
   output logic [1:0]  sf,
   output logic        pred_taken
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_pc_inc;
   logic [31:0] w_redir_pc;
   logic [31:0] w_seq_pc;
   logic        w_pred;
   logic [31:0] w_pred_pc;
   logic        w_flush;
   logic        w_im_oe;

   // pc+4 wraps naturally at 2^32; the redirect target is forced word aligned
   assign w_pc_inc   = r_pc + 32'd4;
   assign w_redir_pc = {ex_target[31:2], 2'b00};
   assign w_seq_pc   = w_pred ? w_pred_pc : w_pc_inc;

`ifdef IF_BHT_EN
   localparam int IW = $clog2(BHT_ENTRIES);

   logic [1:0]    r_bht_cnt [BHT_ENTRIES];
   logic          r_btb_vld [BHT_ENTRIES];
   logic [29:0]   r_btb_tgt [BHT_ENTRIES];
   logic [IW-1:0] w_rd_idx;
   logic [IW-1:0] w_wr_idx;
   logic          w_unused_bht;

   assign w_rd_idx  = r_pc[IW+1:2];
   assign w_wr_idx  = ex_pc[IW+1:2];
   // Lookup reads the registered arrays, so a same-cycle training write is not yet visible
   assign w_pred    = (r_state != S_BOOT) && r_btb_vld[w_rd_idx] && r_bht_cnt[w_rd_idx][1];
   assign w_pred_pc = {r_btb_tgt[w_rd_idx], 2'b00};
   assign w_unused_bht = ^{ex_pc[31:IW+2], ex_pc[1:0], ex_target[1:0]};

   // Predictor training: saturating counter update, BTB fill on taken branches
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            r_bht_cnt[i] <= 2'b01;
            r_btb_vld[i] <= 1'b0;
            r_btb_tgt[i] <= 30'd0;
         end
      end else if (ex_is_branch) begin
         if (ex_taken) begin
            if (r_bht_cnt[w_wr_idx] != 2'b11) begin
               r_bht_cnt[w_wr_idx] <= r_bht_cnt[w_wr_idx] + 2'b01;
            end
            r_btb_tgt[w_wr_idx] <= ex_target[31:2];
            r_btb_vld[w_wr_idx] <= 1'b1;
         end else begin
            if (r_bht_cnt[w_wr_idx] != 2'b00) begin
               r_bht_cnt[w_wr_idx] <= r_bht_cnt[w_wr_idx] - 2'b01;
            end
         end
      end
   end
`else
   logic        w_unused_train;
   logic [31:0] w_unused_cfg;

   // Static not-taken: no predictor state, training inputs have no effect
   assign w_pred         = 1'b0;
   assign w_pred_pc      = 32'd0;
   assign w_unused_train = ^{ex_is_branch, ex_pc, ex_taken, ex_target[1:0]};
   assign w_unused_cfg   = BHT_ENTRIES;
`endif

   // Flush on redirect or during the boot cycle; a stall is only reported when not flushing
   assign w_flush = ex_redirect | (r_state == S_BOOT);

   // Next-state and next-PC: redirect beats stall, stall beats sequential/predicted fetch
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_im_oe     = 1'b1;
      case (r_state)
         S_BOOT: begin
            w_im_oe     = 1'b0;
            w_state_nxt = S_RUN;
         end
         S_RUN, S_HOLD: begin
            if (ex_redirect) begin
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = S_RUN;
            end else if (stall_in) begin
               w_state_nxt = S_HOLD;
            end else begin
               w_pc_nxt    = w_seq_pc;
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            w_im_oe     = 1'b0;
            w_state_nxt = S_BOOT;
         end
      endcase
   end

   // State and PC register; reset overrides every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_BOOT;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   assign im_oe      = w_im_oe;
   assign im_addr    = r_pc;
   assign pc_out     = r_pc;
   assign sf         = {stall_in & ~w_flush, w_flush};
   assign pred_taken = w_pred;

endmodule

// File: tb/tb_if_pc_gen.sv
// tb/tb_if_pc_gen.sv - directed self-checking bench for if_pc_gen
module tb_if_pc_gen;

   logic        clk;
   logic        rst;
   logic        stall_in;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic        im_oe;
   logic [31:0] im_addr;
   logic [31:0] pc_out;
   logic [1:0]  sf;
   logic        pred_taken;

   int n_vec;
   int n_err;

`ifdef IF_BHT_EN
   localparam logic        BHT_ON = 1'b1;
`else
   localparam logic        BHT_ON = 1'b0;
`endif

   if_pc_gen dut (
      .clk          (clk),
      .rst          (rst),
      .stall_in     (stall_in),
      .ex_redirect  (ex_redirect),
      .ex_target    (ex_target),
      .ex_is_branch (ex_is_branch),
      .ex_pc        (ex_pc),
      .ex_taken     (ex_taken),
      .im_oe        (im_oe),
      .im_addr      (im_addr),
      .pc_out       (pc_out),
      .sf           (sf),
      .pred_taken   (pred_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge; inputs are then driven and settled before sampling
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   logic [31:0] exp_addr;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1; stall_in = 1'b0; ex_redirect = 1'b0; ex_target = 32'd0;
      ex_is_branch = 1'b0; ex_pc = 32'd0; ex_taken = 1'b0;

      tick; tick;
      settle;
      chk("rst_oe",   {31'd0, im_oe}, 32'd0);
      chk("rst_addr", im_addr, 32'd0);
      chk("rst_pc",   pc_out, 32'd0);
      chk("rst_sf",   {30'd0, sf}, 32'd1);
      chk("rst_pred", {31'd0, pred_taken}, 32'd0);

      // reset release: one BOOT cycle then back-to-back sequential fetch
      rst = 1'b0;
      settle;
      chk("boot_oe", {31'd0, im_oe}, 32'd0);
      chk("boot_sf", {30'd0, sf}, 32'd1);
      exp_addr = 32'd0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("seq_addr", im_addr, exp_addr);
         chk("seq_oe",   {31'd0, im_oe}, 32'd1);
         chk("seq_sf",   {30'd0, sf}, 32'd0);
         exp_addr = exp_addr + 32'd4;
      end

      // three-cycle stall at 0x10
      stall_in = 1'b1;
      settle;
      chk("stall0_addr", im_addr, 32'h10);
      chk("stall0_sf",   {30'd0, sf}, 32'd2);
      for (int i = 0; i < 2; i++) begin
         tick;
         chk("stall_addr", im_addr, 32'h10);
         chk("stall_sf",   {30'd0, sf}, 32'd2);
         chk("stall_oe",   {31'd0, im_oe}, 32'd1);
      end
      tick;
      stall_in = 1'b0;
      settle;
      chk("unstall_addr", im_addr, 32'h10);
      chk("unstall_sf",   {30'd0, sf}, 32'd0);
      tick;
      chk("resume_addr", im_addr, 32'h14);

      exp_addr = 32'h14;
      for (int i = 0; i < 11; i++) begin
         tick;
         exp_addr = exp_addr + 32'd4;
         chk("run_addr", im_addr, exp_addr);
      end

      // redirect and stall together at 0x40: redirect wins, target low bits dropped
      ex_redirect = 1'b1; ex_target = 32'h203; stall_in = 1'b1;
      settle;
      chk("redir_sf",   {30'd0, sf}, 32'd1);
      chk("redir_addr", im_addr, 32'h40);
      tick;
      ex_redirect = 1'b0; stall_in = 1'b0;
      settle;
      chk("redir_tgt", im_addr, 32'h200);
      chk("redir_oe",  {31'd0, im_oe}, 32'd1);
      tick;
      chk("redir_run", im_addr, 32'h204);

      // wrap at the top of the address space
      ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFE;
      tick;
      ex_redirect = 1'b0;
      settle;
      chk("wrap_top", im_addr, 32'hFFFF_FFFC);
      tick;
      chk("wrap_zero", im_addr, 32'h0);

      // redirect out of HOLD
      stall_in = 1'b1;
      tick;
      chk("hold_addr", im_addr, 32'h0);
      chk("hold_sf",   {30'd0, sf}, 32'd2);
      ex_redirect = 1'b1; ex_target = 32'h300;
      settle;
      chk("hold_redir_sf", {30'd0, sf}, 32'd1);
      tick;
      ex_redirect = 1'b0; stall_in = 1'b0;
      settle;
      chk("hold_redir_addr", im_addr, 32'h300);
      tick;
      chk("hold_redir_run", im_addr, 32'h304);

      // reset while holding
      stall_in = 1'b1;
      tick;
      chk("hold2_addr", im_addr, 32'h304);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      settle;
      chk("rsthold_addr", im_addr, 32'h0);
      chk("rsthold_oe",   {31'd0, im_oe}, 32'd0);
      chk("rsthold_sf",   {30'd0, sf}, 32'd1);
      tick;
      chk("rsthold_run_oe", {31'd0, im_oe}, 32'd1);

      // predictor: two taken trainings of 0x80 -> 0x100 while held
      ex_is_branch = 1'b1; ex_pc = 32'h80; ex_taken = 1'b1; ex_target = 32'h100;
      tick; tick;
      ex_is_branch = 1'b0;
      ex_redirect = 1'b1; ex_target = 32'h80; stall_in = 1'b0;
      tick;
      ex_redirect = 1'b0;
      settle;
      chk("bht_t_addr", im_addr, 32'h80);
      chk("bht_t_pred", {31'd0, pred_taken}, {31'd0, BHT_ON});
      tick;
      chk("bht_t_next", im_addr, BHT_ON ? 32'h100 : 32'h84);

      // two not-taken trainings bring the counter back below threshold
      stall_in = 1'b1;
      ex_is_branch = 1'b1; ex_pc = 32'h80; ex_taken = 1'b0;
      tick; tick;
      ex_is_branch = 1'b0;
      ex_redirect = 1'b1; ex_target = 32'h80; stall_in = 1'b0;
      tick;
      ex_redirect = 1'b0;
      settle;
      chk("bht_nt_addr", im_addr, 32'h80);
      chk("bht_nt_pred", {31'd0, pred_taken}, 32'd0);
      tick;
      chk("bht_nt_next", im_addr, 32'h84);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/if_pc_gen.md
# if_pc_gen

Instruction-fetch PC generator for the five-stage RV32I core. Holds the architectural fetch PC, drives the synchronous instruction-memory address, and feeds the IF/ID pipeline register its PC and stall/flush control. It resolves next-PC priority among reset, EX-stage redirect, hazard stall and sequential/predicted fetch. It sits directly upstream of IF/ID.

## Interface

- RESET_PC, 32'h0000_0000, first fetch address after reset
- BHT_ENTRIES, 16, predictor entries, power of two, 4..256; used only with IF_BHT_EN

- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_in  in  1  load-use stall request from hazard unit
- ex_redirect  in  1  EX resolved a control transfer whose fetch was wrong
- ex_target  in  32  correct next PC from EX; bits [1:0] ignored, treated as 0
- ex_is_branch  in  1  EX holds a conditional branch (predictor training)
- ex_pc  in  32  PC of the EX instruction (training)
- ex_taken  in  1  actual branch outcome (training)
- im_oe  out  1  instruction-memory read enable
- im_addr  out  32  instruction-memory address, registered
- pc_out  out  32  PC issued this cycle, to IF/ID pc_in
- sf  out  2  to IF/ID: sf[1] stall, sf[0] flush
- pred_taken  out  1  prediction for pc_out; constant 0 without IF_BHT_EN

## Operation

- FSM states: BOOT, RUN, HOLD.
- rst high: state<=BOOT, pc<=RESET_PC, all BHT counters<=2'b01, all BTB valid bits<=0.
- BOOT (exactly one cycle after rst falls): im_oe=0, sf=2'b01, pc held; -> RUN.
- RUN: im_oe=1. Next-PC priority: ex_redirect -> {ex_target[31:2],2'b00}; else stall_in -> hold pc, go HOLD; else predicted-taken -> BTB target; else pc+4.
- HOLD: im_oe=1, im_addr held, sf=2'b10. stall_in still high -> stay; stall_in low -> pc+4 (or prediction), -> RUN; ex_redirect -> load ex_target, -> RUN.
- ex_redirect with stall_in in same cycle: redirect wins, sf=2'b01, stall ignored.
- sf (combinational): sf[0]=ex_redirect|(state==BOOT); sf[1]=stall_in & ~sf[0].
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
- im_addr and pc_out always equal the current pc register.

## Timing

- Reset values: im_oe=0, im_addr=pc_out=RESET_PC, sf=2'b01, pred_taken=0.
- Redirect latency: ex_redirect sampled at edge N -> im_addr=ex_target from cycle N+1.
- Stall: im_addr unchanged for every cycle stall_in is high, advances the cycle after it falls.
- Sequential fetch: one new address per cycle in RUN, no bubbles.
- rst asserted mid-stall or mid-redirect: takes effect at next edge, overrides all inputs.

## Configuration

- IF_BHT_EN defined: BHT_ENTRIES 2-bit saturating counters plus BTB (valid, 30-bit target), indexed pc[log2(BHT_ENTRIES)+1:2], untagged. Predict taken when valid and counter>=2'b10; pred_taken=1 and next pc=BTB target. Training when ex_is_branch: counter inc (taken, sat 11) / dec (not taken, sat 00) at index of ex_pc; on taken, write ex_target into BTB, set valid. Training and lookup same index same cycle: lookup sees old value.
- IF_BHT_EN undefined: no arrays; static not-taken, pred_taken=0, training inputs ignored.

## Test plan

- Reset release, RESET_PC=0: cycle 1 BOOT im_oe=0 sf=01; then im_addr 0,4,8,12 on consecutive cycles, sf=00.
- stall_in high 3 cycles while im_addr=0x10: im_addr stays 0x10, sf=10 for 3 cycles, next cycle 0x14.
- ex_redirect with ex_target=0x203 and stall_in both high at im_addr=0x40: sf=01, next im_addr=0x200, FSM in RUN.
- pc=0xFFFF_FFFC, no stall: next im_addr=0x0000_0000.
- IF_BHT_EN: train ex_pc=0x80 taken to 0x100 twice -> later fetch of 0x80 gives pred_taken=1, next im_addr=0x100; two not-taken trainings -> pred_taken=0, next 0x84.
- rst asserted while in HOLD: next cycle BOOT, im_addr=RESET_PC, im_oe=0.
